// File: rtl/ptcalc_sched_pkg.sv
// Shared types and constants for the pT-calculator segment scheduler.
// Holds the scheduler FSM state type, default word widths and the
// drop-counter width, plus a saturating-increment helper.
package ptcalc_sched_pkg;

    localparam int PTCALC_PL_W  = 58;
    localparam int PTCALC_SEG_W = 64;
    localparam int PTCALC_OUT_W = 54;
    localparam int DROP_CNT_W   = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        LAUNCH  = 2'd2,
        WAIT    = 2'd3
    } sched_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] value);
        return (&value) ? value : value + DROP_CNT_W'(1);
    endfunction

endpackage

// File: rtl/ptcalc_result_fifo.sv
// Synchronous result FIFO for the pT-calculator scheduler.
// Pointers wrap modulo DEPTH; the head word is registered so the
// consumer sees a flop output. Flags: full, empty, almost_full
// (count == DEPTH-1). A push into a full FIFO is only accepted when a
// pop happens in the same cycle.
module ptcalc_result_fifo #(
    parameter int WIDTH = 54,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic             almost_full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [WIDTH-1:0] head_next;
    logic             push_en;
    logic             pop_en;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign empty       = (count == '0);
    assign full        = (count == CNT_W'(DEPTH));
    assign almost_full = (count == CNT_W'(DEPTH - 1));
    assign pop_en      = pop && !empty;
    assign push_en     = push && (!full || pop_en);

    // Next read pointer, occupancy and the word that will sit at the head.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        rd_ptr_next = pop_en ? ptr_inc(rd_ptr) : rd_ptr;
        count_next  = count + CNT_W'(push_en) - CNT_W'(pop_en);
        head_next   = head_data;
        if (push_en && (count == CNT_W'(pop_en))) begin
            // The FIFO is (or becomes) empty apart from the word being written.
            head_next = push_data;
        end else if (count_next != '0) begin
            head_next = mem[rd_ptr_next];
        end
    end

    // Pointer, count and registered head update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            head_data <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops
            // see the pre-edge values of one another.
            if (push_en) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            rd_ptr    <= rd_ptr_next;
            count     <= count_next;
            head_data <= head_next;
        end
    end

    // Storage array write.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; count gates every read, so stale
        // contents are never observed and the array can map to plain RAM.
        if (push_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/ptcalc_seg_scheduler.sv
// Front-end scheduler for the HLS pT-calculator core.
// Captures a pipeline-slot word, collects one segment per station within
// a TIMEOUT window, launches the core via ap_start/ap_ready (missing
// stations zeroed) and queues results in a FIFO with valid/ready.
// Optional build macro PTCALC_SEGMASK_EN adds out_segmask, the
// collection mask stored alongside each queued result.
module ptcalc_seg_scheduler
    import ptcalc_sched_pkg::*;
#(
    parameter int N_STATIONS = 3,
    parameter int PL_W       = PTCALC_PL_W,
    parameter int SEG_W      = PTCALC_SEG_W,
    parameter int OUT_W      = PTCALC_OUT_W,
    parameter int TIMEOUT    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst,
    input  logic                        is_C_side,
    input  logic                        pl_dv,
    input  logic [PL_W-1:0]             pl_data,
    input  logic [N_STATIONS-1:0]       seg_dv,
    input  logic [N_STATIONS*SEG_W-1:0] seg_data,
    output logic                        core_start,
    input  logic                        core_ready,
    output logic [PL_W-1:0]             core_pl,
    output logic [N_STATIONS*SEG_W-1:0] core_seg,
    output logic                        core_is_C_side,
    input  logic [OUT_W-1:0]            core_result,
    input  logic                        core_result_vld,
    output logic [OUT_W-1:0]            out_data,
    output logic                        out_dv,
    input  logic                        out_ready,
`ifdef PTCALC_SEGMASK_EN
    output logic [N_STATIONS-1:0]       out_segmask,
`endif
    output logic                        busy,
    output logic [DROP_CNT_W-1:0]       drop_cnt
);

    localparam int TIMER_W = $clog2(TIMEOUT + 1);
`ifdef PTCALC_SEGMASK_EN
    localparam int FIFO_W = OUT_W + N_STATIONS;
`else
    localparam int FIFO_W = OUT_W;
`endif

    sched_state_t state_q;
    sched_state_t state_d;

    logic [PL_W-1:0]             pl_q;
    logic                        is_c_q;
    logic [N_STATIONS*SEG_W-1:0] seg_q;
    logic [N_STATIONS-1:0]       mask_q;
    logic [N_STATIONS-1:0]       seg_take;
    logic [N_STATIONS-1:0]       mask_after;
    logic [TIMER_W-1:0]          timer_q;
    logic [DROP_CNT_W-1:0]       drop_q;
    logic                        capture;

    logic              fifo_push;
    logic              fifo_pop;
    logic [FIFO_W-1:0] fifo_push_data;
    logic [FIFO_W-1:0] fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_almost_full;

    assign capture = (state_q == IDLE) && pl_dv;

    // Stations captured this cycle and the mask they produce.
    always_comb begin
        seg_take   = '0;
        mask_after = mask_q;
        case (state_q)
            IDLE: begin
                if (pl_dv) begin
                    seg_take   = seg_dv;
                    mask_after = seg_dv;
                end
            end
            COLLECT: begin
                // First arrival per station wins; duplicates are ignored.
                seg_take   = seg_dv & ~mask_q;
                mask_after = mask_q | seg_take;
            end
            default: ;
        endcase
    end

    // Next-state and core launch handshake.
    always_comb begin
        state_d    = state_q;
        core_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (pl_dv) begin
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (&mask_after) begin
                    state_d = LAUNCH;
                end else if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
                    // An empty slot is abandoned without launching the core.
                    state_d = (|mask_after) ? LAUNCH : IDLE;
                end
            end
            LAUNCH: begin
                // Only one slot is ever in flight, so a non-full FIFO
                // guarantees room for the result of this launch.
                if (!fifo_full) begin
                    core_start = 1'b1;
                    if (core_ready) begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (core_result_vld) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Slot word, side flag, segments, mask and collection timer.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            pl_q    <= '0;
            is_c_q  <= 1'b0;
            seg_q   <= '0;
            mask_q  <= '0;
            timer_q <= '0;
        end else begin
            if (capture) begin
                pl_q   <= pl_data;
                is_c_q <= is_C_side;
            end
            if (capture || (state_q == COLLECT)) begin
                mask_q <= mask_after;
            end
            for (int i = 0; i < N_STATIONS; i++) begin
                if (seg_take[i]) begin
                    seg_q[i*SEG_W +: SEG_W] <= seg_data[i*SEG_W +: SEG_W];
                end else if (capture) begin
                    seg_q[i*SEG_W +: SEG_W] <= '0;
                end
            end
            timer_q <= (state_q == COLLECT) ? timer_q + TIMER_W'(1) : '0;
        end
    end

    // Saturating count of slot words offered while not idle.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            drop_q <= '0;
        end else if (pl_dv && (state_q != IDLE)) begin
            drop_q <= sat_inc(drop_q);
        end
    end

    assign core_pl        = pl_q;
    assign core_seg       = seg_q;
    assign core_is_C_side = is_c_q;
    assign busy           = (state_q != IDLE);
    assign drop_cnt       = drop_q;

    // Results are only accepted while waiting on a launched slot, so a
    // late result after reset or abort never reaches the FIFO.
    assign fifo_push = (state_q == WAIT) && core_result_vld;
    assign fifo_pop  = out_dv && out_ready;
    assign out_dv    = !fifo_empty;

`ifdef PTCALC_SEGMASK_EN
    assign fifo_push_data          = {mask_q, core_result};
    assign {out_segmask, out_data} = fifo_head;
`else
    assign fifo_push_data = core_result;
    assign out_data       = fifo_head;
`endif

    ptcalc_result_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_result_fifo (
        .clk         (ap_clk),
        .rst         (ap_rst),
        .push        (fifo_push),
        .push_data   (fifo_push_data),
        .pop         (fifo_pop),
        .head_data   (fifo_head),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .almost_full (fifo_almost_full)
    );

    // Launch gating must make an overflowing push impossible.
    a_no_overflow : assert property (@(posedge ap_clk) disable iff (ap_rst)
        fifo_push |-> (!fifo_full || fifo_pop));

    // The FIFO can only become full from the almost-full level.
    a_full_from_almost : assert property (@(posedge ap_clk) disable iff (ap_rst)
        $rose(fifo_full) |-> $past(fifo_almost_full));

endmodule

// File: tb/tb_ptcalc_seg_scheduler.sv
// Self-checking bench for ptcalc_seg_scheduler (default parameters).
// Table of single-slot transactions plus hand-written sequences for
// late segments, drops/saturation, FIFO backpressure and async reset.
module tb_ptcalc_seg_scheduler;

    localparam int NS    = 3;
    localparam int PL_W  = 58;
    localparam int SEG_W = 64;
    localparam int OUT_W = 54;

    logic                  ap_clk = 1'b0;
    logic                  ap_rst;
    logic                  is_C_side;
    logic                  pl_dv;
    logic [PL_W-1:0]       pl_data;
    logic [NS-1:0]         seg_dv;
    logic [NS*SEG_W-1:0]   seg_data;
    logic                  core_start;
    logic                  core_ready;
    logic [PL_W-1:0]       core_pl;
    logic [NS*SEG_W-1:0]   core_seg;
    logic                  core_is_C_side;
    logic [OUT_W-1:0]      core_result;
    logic                  core_result_vld;
    logic [OUT_W-1:0]      out_data;
    logic                  out_dv;
    logic                  out_ready;
`ifdef PTCALC_SEGMASK_EN
    logic [NS-1:0]         out_segmask;
`endif
    logic                  busy;
    logic [15:0]           drop_cnt;

    ptcalc_seg_scheduler #(
        .N_STATIONS (NS),
        .PL_W       (PL_W),
        .SEG_W      (SEG_W),
        .OUT_W      (OUT_W),
        .TIMEOUT    (16),
        .FIFO_DEPTH (4)
    ) dut (
        .ap_clk          (ap_clk),
        .ap_rst          (ap_rst),
        .is_C_side       (is_C_side),
        .pl_dv           (pl_dv),
        .pl_data         (pl_data),
        .seg_dv          (seg_dv),
        .seg_data        (seg_data),
        .core_start      (core_start),
        .core_ready      (core_ready),
        .core_pl         (core_pl),
        .core_seg        (core_seg),
        .core_is_C_side  (core_is_C_side),
        .core_result     (core_result),
        .core_result_vld (core_result_vld),
        .out_data        (out_data),
        .out_dv          (out_dv),
        .out_ready       (out_ready),
`ifdef PTCALC_SEGMASK_EN
        .out_segmask     (out_segmask),
`endif
        .busy            (busy),
        .drop_cnt        (drop_cnt)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        logic [PL_W-1:0]     pl;
        logic                is_c;
        logic [NS-1:0]       seg_dv;
        logic [NS*SEG_W-1:0] segs;
        logic [NS*SEG_W-1:0] exp_seg;
        logic [OUT_W-1:0]    res;
        int                  start_off;   // cycles from capture to core_start, 0 = no launch
    } vec_t;

    vec_t vecs[5];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
        cyc++;
    endtask

    task automatic wait_launch(input int limit, output bit seen);
        seen = 1'b0;
        while (!seen && cyc < limit) begin
            if (core_start) seen = 1'b1;
            else tick();
        end
        if (core_start) seen = 1'b1;
    endtask

    // From a cycle with core_start high: hold one cycle, handshake, return res.
    task automatic finish_slot(input logic [OUT_W-1:0] res);
        tick();
        check("start_hold", core_start, 1);
        core_ready = 1'b1;
        tick();
        core_ready = 1'b0;
        check("start_drop", core_start, 0);
        check("wait_busy", busy, 1);
        core_result     = res;
        core_result_vld = 1'b1;
        tick();
        core_result_vld = 1'b0;
        check("idle_after_result", busy, 0);
    endtask

    task automatic start_slot(input logic [PL_W-1:0] pl, input logic is_c,
                              input logic [NS-1:0] dv, input logic [NS*SEG_W-1:0] segs);
        pl_dv     = 1'b1;
        pl_data   = pl;
        is_C_side = is_c;
        seg_dv    = dv;
        seg_data  = segs;
        cyc       = 0;
        tick();
        pl_dv    = 1'b0;
        seg_dv   = '0;
        seg_data = ~segs;
    endtask

    task automatic run_slot(input vec_t v);
        bit seen;
        start_slot(v.pl, v.is_c, v.seg_dv, v.segs);
        if (v.start_off == 0) begin
            seen = 1'b0;
            while (cyc < 16) begin
                seen |= core_start;
                tick();
            end
            check("empty_busy_last", busy, 1);
            seen |= core_start;
            tick();
            check("empty_idle", busy, 0);
            check("empty_no_start", seen, 0);
            check("empty_no_out", out_dv, 0);
            check("empty_seg", core_seg, 0);
        end else begin
            wait_launch(40, seen);
            check("launch_seen", seen, 1);
            check("launch_cycle", cyc, v.start_off);
            check("core_seg", core_seg, v.exp_seg);
            check("core_pl", core_pl, v.pl);
            check("core_side", core_is_C_side, v.is_c);
            finish_slot(v.res);
            check("out_dv", out_dv, 1);
            check("out_data", out_data, v.res);
`ifdef PTCALC_SEGMASK_EN
            check("out_segmask", out_segmask, v.seg_dv);
`endif
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check("popped_empty", out_dv, 0);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        logic [OUT_W-1:0] exp_q[$];

        vecs[0] = '{58'h2A5, 1'b0, 3'b111,
                    {64'h33, 64'h22, 64'h11}, {64'h33, 64'h22, 64'h11},
                    54'h1234, 2};
        vecs[1] = '{58'h3FF_FFFF_FFFF_FFFF, 1'b1, 3'b111,
                    {64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 64'hDEAD_BEEF_0BAD_F00D},
                    {64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 64'hDEAD_BEEF_0BAD_F00D},
                    54'h3F_FFFF_FFFF_FFFF, 2};
        vecs[2] = '{58'h0DE, 1'b1, 3'b010,
                    {64'hAAAA, 64'hBBBB, 64'hCCCC}, {64'h0, 64'hBBBB, 64'h0},
                    54'hABC, 17};
        vecs[3] = '{58'h155, 1'b0, 3'b000,
                    {64'h1, 64'h2, 64'h3}, {64'h0, 64'h0, 64'h0},
                    54'h0, 0};
        vecs[4] = '{58'h0A0, 1'b0, 3'b101,
                    {64'h5151, 64'h6262, 64'h7373}, {64'h5151, 64'h0, 64'h7373},
                    54'h2_0000_0000_0001, 17};

        ap_rst          = 1'b1;
        is_C_side       = 1'b0;
        pl_dv           = 1'b0;
        pl_data         = '0;
        seg_dv          = '0;
        seg_data        = '0;
        core_ready      = 1'b0;
        core_result     = '0;
        core_result_vld = 1'b0;
        out_ready       = 1'b0;

        // Reset state.
        #12;
        check("rst_core_start", core_start, 0);
        check("rst_out_dv", out_dv, 0);
        check("rst_busy", busy, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_core_pl", core_pl, 0);
        check("rst_core_seg", core_seg, 0);
        check("rst_core_side", core_is_C_side, 0);
        ap_rst = 1'b0;
        tick();

        // Table-driven single slots.
        for (int i = 0; i < 5; i++) begin
            run_slot(vecs[i]);
        end

        // Segments without a slot word are ignored in IDLE.
        seg_dv   = 3'b111;
        seg_data = {64'h9, 64'h8, 64'h7};
        tick();
        seg_dv = '0;
        check("seg_alone_idle", busy, 0);

        // Late single segment with a later duplicate; timeout launch.
        start_slot(58'h5A, 1'b0, 3'b000, {64'hE1, 64'hE2, 64'hE3});
        seg_dv   = 3'b010;
        seg_data = {64'hEE, 64'h55, 64'hEE};
        tick();
        seg_data = {64'hEE, 64'h99, 64'hEE};
        tick();
        seg_dv = '0;
        wait_launch(40, seen);
        check("late_launch_seen", seen, 1);
        check("late_launch_cycle", cyc, 17);
        check("late_core_seg", core_seg, {64'h0, 64'h55, 64'h0});
        finish_slot(54'hC0FFEE);
        check("late_out_data", out_data, 54'hC0FFEE);
`ifdef PTCALC_SEGMASK_EN
        check("late_segmask", out_segmask, 3'b010);
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Drops while busy, then saturation.
        start_slot(58'h77, 1'b1, 3'b111, {64'h3, 64'h2, 64'h1});
        wait_launch(40, seen);
        check("drop_launch_seen", seen, 1);
        for (int k = 0; k < 3; k++) begin
            pl_dv   = 1'b1;
            pl_data = PL_W'(k + 1);
            tick();
            pl_dv = 1'b0;
            tick();
        end
        check("drop_cnt_3", drop_cnt, 3);
        check("drop_core_pl", core_pl, 58'h77);
        check("drop_start_held", core_start, 1);
        core_ready = 1'b1;
        tick();
        core_ready = 1'b0;
        pl_dv = 1'b1;
        repeat (65532) tick();
        pl_dv = 1'b0;
        check("drop_cnt_max", drop_cnt, 16'hFFFF);
        pl_dv = 1'b1;
        tick();
        pl_dv = 1'b0;
        check("drop_cnt_sat", drop_cnt, 16'hFFFF);
        check("drop_core_pl_end", core_pl, 58'h77);
        core_result     = 54'h777;
        core_result_vld = 1'b1;
        tick();
        core_result_vld = 1'b0;
        check("drop_out_data", out_data, 54'h777);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Backpressure: four results fill the FIFO, fifth launch waits.
        for (int k = 0; k < 4; k++) begin
            start_slot(PL_W'(58'h100 + k), 1'b0, 3'b111, {64'h3, 64'h2, 64'h1});
            wait_launch(40, seen);
            finish_slot(OUT_W'(54'h101 + k));
            check("bp_out_dv", out_dv, 1);
        end
        start_slot(58'h105, 1'b0, 3'b111, {64'h3, 64'h2, 64'h1});
        tick();
        check("bp_hold_start", core_start, 0);
        check("bp_hold_busy", busy, 1);
        tick();
        tick();
        check("bp_hold_start2", core_start, 0);
        check("bp_head_first", out_data, 54'h101);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_start_after_pop", core_start, 1);
        check("bp_head_second", out_data, 54'h102);
        finish_slot(54'h105);
        exp_q = '{54'h102, 54'h103, 54'h104, 54'h105};
        foreach (exp_q[k]) begin
            check("bp_drain_dv", out_dv, 1);
            check("bp_drain_data", out_data, exp_q[k]);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        check("bp_drained", out_dv, 0);

        // Asynchronous reset during WAIT with a queued result.
        start_slot(58'h3A, 1'b0, 3'b111, {64'h3, 64'h2, 64'h1});
        wait_launch(40, seen);
        finish_slot(54'h3AA);
        start_slot(58'h3B, 1'b1, 3'b111, {64'h6, 64'h5, 64'h4});
        wait_launch(40, seen);
        core_ready = 1'b1;
        tick();
        core_ready = 1'b0;
        check("pre_rst_busy", busy, 1);
        check("pre_rst_out_dv", out_dv, 1);
        #2;
        ap_rst = 1'b1;
        #1;
        check("arst_core_start", core_start, 0);
        check("arst_out_dv", out_dv, 0);
        check("arst_busy", busy, 0);
        check("arst_drop_cnt", drop_cnt, 0);
        check("arst_core_pl", core_pl, 0);
        check("arst_core_seg", core_seg, 0);
        check("arst_core_side", core_is_C_side, 0);
        check("arst_out_data", out_data, 0);
        #1;
        ap_rst = 1'b0;
        tick();
        core_result     = 54'h2BB;
        core_result_vld = 1'b1;
        tick();
        core_result_vld = 1'b0;
        tick();
        check("late_result_ignored", out_dv, 0);
        check("late_result_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
